// File: rtl/stream_width_converter_pkg.sv
// stream_width_converter_pkg: end-of-stream state encoding and sizing helpers shared by the converter
package stream_width_converter_pkg;
  typedef enum logic [1:0] {S_STREAM, S_FLUSH, S_DONE} state_t;
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/stream_width_converter_unit_shift_buffer.sv
// unit_shift_buffer: U-bit unit FIFO with parallel push of NI units and pop of NO units
// Oldest unit sits at the LSB; slots at or above count are always zero, so a short pop is already zero-padded.
module unit_shift_buffer
  import stream_width_converter_pkg::*;
#(
  parameter int U     = 2,
  parameter int NI    = 4,
  parameter int NO    = 1,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [NI*U-1:0]   push_data_i,
  input  logic              pop_i,
  output logic [NO*U-1:0]   head_o,
  output logic [CW-1:0]     count_o,
  output logic [CW-1:0]     free_o
);
  logic [DEPTH*U-1:0] data_q, data_d, kept;
  logic [CW-1:0] count_q, count_d, base;
  always_comb begin
    base    = pop_i ? (count_q > CW'(NO) ? count_q - CW'(NO) : '0) : count_q;
    kept    = pop_i ? data_q >> (NO*U) : data_q;
    data_d  = push_i ? (kept | ((DEPTH*U)'(push_data_i) << (int'(base) * U))) : kept;
    count_d = push_i ? base + CW'(NI) : base;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
  assign head_o  = data_q[NO*U-1:0];
  assign count_o = count_q;
  assign free_o  = CW'(DEPTH) - count_q;
endmodule

// File: rtl/stream_width_converter.sv
// stream_width_converter: IN_LEN->OUT_LEN stream gearbox with buffering, request credits,
// end-of-stream flush of a partial word and a sticky overflow flag.
module stream_width_converter
  import stream_width_converter_pkg::*;
#(
  parameter int IN_LEN       = 8,
  parameter int OUT_LEN      = 2,
  parameter int MSB_FIRST    = 0,
  parameter int BUF_WORDS    = 2,
  parameter int MAX_INFLIGHT = 2,
  parameter int PAD_PARTIAL  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inclk_i,
  input  logic [IN_LEN-1:0]  in_i,
  input  logic               in_done_i,
  input  logic               downstream_rdy_i,
  output logic               readclk_o,
  output logic               outclk_o,
  output logic [OUT_LEN-1:0] out_o,
  output logic               rdy_o,
  output logic               done_o,
  output logic               overflow_o
);
  localparam int U     = imin(IN_LEN, OUT_LEN);
  localparam int NI    = IN_LEN / U;
  localparam int NO    = OUT_LEN / U;
  localparam int DEPTH = BUF_WORDS * imax(IN_LEN, OUT_LEN) / U;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int KW    = $clog2(MAX_INFLIGHT + 1);
  logic [IN_LEN-1:0] push_units;
  logic [OUT_LEN-1:0] head, head_fmt, out_q;
  logic [CW-1:0] count, free;
  logic [KW-1:0] credits_q, credits_d;
  logic push, pop, emit, fin, readclk_d, readclk_q, outclk_q, done_q, overflow_q;
  state_t state_q, state_d;
  genvar k;
  for (k = 0; k < NI; k++) begin : g_in
    assign push_units[k*U +: U] = MSB_FIRST != 0 ? in_i[(NI-1-k)*U +: U] : in_i[k*U +: U];
  end
  for (k = 0; k < NO; k++) begin : g_out
    assign head_fmt[k*U +: U] = MSB_FIRST != 0 ? head[(NO-1-k)*U +: U] : head[k*U +: U];
  end
  unit_shift_buffer #(.U(U), .NI(NI), .NO(NO), .DEPTH(DEPTH), .CW(CW)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_units),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .free_o      (free)
  );
  // A word arriving in the same cycle still belongs to the stream, so flushing waits for a quiet input.
  always_comb begin
    fin       = (state_q == S_FLUSH || in_done_i) && !inclk_i;
    push      = inclk_i && free >= CW'(NI);
    emit      = downstream_rdy_i && (count >= CW'(NO) || (fin && count != '0 && PAD_PARTIAL != 0));
    pop       = emit || (fin && count != '0 && count < CW'(NO) && PAD_PARTIAL == 0);
    state_d   = fin && count == '0 ? S_DONE : in_done_i ? S_FLUSH : state_q == S_DONE ? S_STREAM : state_q;
    readclk_d = state_q != S_FLUSH && !in_done_i && credits_q < KW'(MAX_INFLIGHT) &&
                int'(free) >= (int'(credits_q) + 1) * NI;
    credits_d = state_d == S_DONE ? '0 :
                readclk_d && !inclk_i ? credits_q + KW'(1) :
                !readclk_d && inclk_i && credits_q != '0 ? credits_q - KW'(1) : credits_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_STREAM;
      credits_q  <= '0;
      readclk_q  <= 1'b0;
      outclk_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      readclk_q  <= readclk_d;
      outclk_q   <= emit;
      done_q     <= state_d == S_DONE;
      overflow_q <= overflow_q | (inclk_i && !push);
      if (emit) out_q <= head_fmt;
    end
  end
  assign readclk_o  = readclk_q;
  assign outclk_o   = outclk_q;
  assign out_o      = out_q;
  assign rdy_o      = free >= CW'(NI);
  assign done_o     = done_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_stream_width_converter.sv
// tb_stream_width_converter: four converter configurations checked against a queue-based reference model
module tb_stream_width_converter;
  logic clk = 1'b0, rst = 1'b1;
  logic a_inclk = 0, a_in_done = 0, a_drdy = 0;
  logic [7:0] a_in = 0;
  logic b_inclk = 0, b_in_done = 0, b_drdy = 0;
  logic [1:0] b_in = 0;
  logic rc0, rc1, rc2, rc3, oc0, oc1, oc2, oc3, ry0, ry1, ry2, ry3;
  logic dd0, dd1, dd2, dd3, ov0, ov1, ov2, ov3;
  logic [1:0] o0, o1;
  logic [7:0] o2, o3;
  logic [1:0] q0[$], q1[$];
  logic [7:0] q2[$], q3[$];
  int nd0 = 0, nd1 = 0, nd2 = 0, nd3 = 0;
  int checks = 0, errors = 0;
  logic [1:0] lsb_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] msb_tab[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] dib_tab[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  always #5 clk = ~clk;

  stream_width_converter #(.IN_LEN(8), .OUT_LEN(2), .MSB_FIRST(0)) u0 (
    .clk(clk), .rst(rst), .inclk_i(a_inclk), .in_i(a_in), .in_done_i(a_in_done), .downstream_rdy_i(a_drdy),
    .readclk_o(rc0), .outclk_o(oc0), .out_o(o0), .rdy_o(ry0), .done_o(dd0), .overflow_o(ov0));
  stream_width_converter #(.IN_LEN(8), .OUT_LEN(2), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .inclk_i(a_inclk), .in_i(a_in), .in_done_i(a_in_done), .downstream_rdy_i(a_drdy),
    .readclk_o(rc1), .outclk_o(oc1), .out_o(o1), .rdy_o(ry1), .done_o(dd1), .overflow_o(ov1));
  stream_width_converter #(.IN_LEN(2), .OUT_LEN(8), .PAD_PARTIAL(1)) u2 (
    .clk(clk), .rst(rst), .inclk_i(b_inclk), .in_i(b_in), .in_done_i(b_in_done), .downstream_rdy_i(b_drdy),
    .readclk_o(rc2), .outclk_o(oc2), .out_o(o2), .rdy_o(ry2), .done_o(dd2), .overflow_o(ov2));
  stream_width_converter #(.IN_LEN(2), .OUT_LEN(8), .PAD_PARTIAL(0)) u3 (
    .clk(clk), .rst(rst), .inclk_i(b_inclk), .in_i(b_in), .in_done_i(b_in_done), .downstream_rdy_i(b_drdy),
    .readclk_o(rc3), .outclk_o(oc3), .out_o(o3), .rdy_o(ry3), .done_o(dd3), .overflow_o(ov3));

  always @(negedge clk) begin
    if (oc0) q0.push_back(o0);
    if (oc1) q1.push_back(o1);
    if (oc2) q2.push_back(o2);
    if (oc3) q3.push_back(o3);
    if (dd0) nd0++;
    if (dd1) nd1++;
    if (dd2) nd2++;
    if (dd3) nd3++;
  end

  function automatic logic [1:0] dibit(input logic [7:0] b, input int k, input bit msb);
    return msb ? 2'((b >> (6 - 2*k)) & 8'h3) : 2'((b >> (2*k)) & 8'h3);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    nd0 = 0; nd1 = 0; nd2 = 0; nd3 = 0;
  endtask

  task automatic apply_reset;
    rst = 1;
    a_inclk = 0; a_in_done = 0; a_drdy = 0; a_in = 0;
    b_inclk = 0; b_in_done = 0; b_drdy = 0; b_in = 0;
    tick; tick;
    rst = 0;
    clear_q;
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    @(negedge clk);
    checks++; if ({oc0, rc0, dd0, ov0, ry0, o0} !== 7'b0000100) begin errors++; $display("FAIL reset_u0 got %b want 0000100", {oc0, rc0, dd0, ov0, ry0, o0}); end
    checks++; if ({oc1, rc1, dd1, ov1, ry1, o1} !== 7'b0000100) begin errors++; $display("FAIL reset_u1 got %b want 0000100", {oc1, rc1, dd1, ov1, ry1, o1}); end
    checks++; if ({oc2, rc2, dd2, ov2, ry2, o2} !== 13'b0000100000000) begin errors++; $display("FAIL reset_u2 got %b", {oc2, rc2, dd2, ov2, ry2, o2}); end
    checks++; if ({oc3, rc3, dd3, ov3, ry3, o3} !== 13'b0000100000000) begin errors++; $display("FAIL reset_u3 got %b", {oc3, rc3, dd3, ov3, ry3, o3}); end
    tick;
    rst = 0;
  endtask

  task automatic test_order;
    logic [1:0] l0, l1;
    logic st;
    apply_reset;
    l0 = 0; l1 = 0;
    a_drdy = 1; a_inclk = 1; a_in = 8'hB4; a_in_done = 1;
    tick;
    a_inclk = 0; a_in_done = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      st = i >= 1 && i <= 4;
      if (st) begin l0 = lsb_tab[i-1]; l1 = msb_tab[i-1]; end
      checks++; if ({oc0, o0, dd0} !== {st, l0, i == 5}) begin errors++; $display("FAIL order_lsb cyc%0d got %b want %b", i, {oc0, o0, dd0}, {st, l0, i == 5}); end
      checks++; if ({oc1, o1, dd1} !== {st, l1, i == 5}) begin errors++; $display("FAIL order_msb cyc%0d got %b want %b", i, {oc1, o1, dd1}, {st, l1, i == 5}); end
    end
  endtask

  task automatic test_2to8;
    apply_reset;
    b_drdy = 1;
    for (int k = 0; k < 4; k++) begin
      b_inclk = 1; b_in = dib_tab[k];
      tick;
    end
    b_inclk = 0;
    tick; tick;
    checks++; if (q2.size() != 1 || q2[0] !== 8'h2D) begin errors++; $display("FAIL pack_u2 got n=%0d first=%h want n=1 2d", q2.size(), q2.size() > 0 ? q2[0] : 8'h00); end
    checks++; if (q3.size() != 1 || q3[0] !== 8'h2D) begin errors++; $display("FAIL pack_u3 got n=%0d first=%h want n=1 2d", q3.size(), q3.size() > 0 ? q3[0] : 8'h00); end
    b_in_done = 1;
    tick;
    b_in_done = 0;
    @(negedge clk);
    checks++; if ({dd2, dd3, oc2, oc3} !== 4'b1100) begin errors++; $display("FAIL empty_done got %b want 1100", {dd2, dd3, oc2, oc3}); end
    @(negedge clk);
    checks++; if ({dd2, dd3, q2.size() == 1} !== 3'b001) begin errors++; $display("FAIL empty_done_pulse got %b want 001", {dd2, dd3, q2.size() == 1}); end
  endtask

  task automatic test_pad;
    apply_reset;
    b_drdy = 1;
    for (int k = 0; k < 3; k++) begin
      b_inclk = 1; b_in = 2'b11; b_in_done = k == 2;
      tick;
    end
    b_inclk = 0; b_in_done = 0;
    for (int c = 0; c < 50 && (nd2 == 0 || nd3 == 0); c++) tick;
    checks++; if (nd2 != 1 || nd3 != 1) begin errors++; $display("FAIL pad_done got %0d/%0d want 1/1", nd2, nd3); end
    checks++; if (q2.size() != 1 || q2[0] !== 8'h3F) begin errors++; $display("FAIL pad_word got n=%0d first=%h want n=1 3f", q2.size(), q2.size() > 0 ? q2[0] : 8'h00); end
    checks++; if (q3.size() != 0) begin errors++; $display("FAIL pad_discard got n=%0d want 0", q3.size()); end
  endtask

  task automatic test_overflow;
    logic [7:0] bb[3];
    apply_reset;
    for (int k = 0; k < 3; k++) begin
      bb[k] = 8'($urandom);
      a_inclk = 1; a_in = bb[k];
      tick;
    end
    a_inclk = 0;
    tick;
    checks++; if ({ov0, ov1, ry0, q0.size() == 0} !== 4'b1101) begin errors++; $display("FAIL ovf_flag got %b want 1101", {ov0, ov1, ry0, q0.size() == 0}); end
    a_drdy = 1; a_in_done = 1;
    tick;
    a_in_done = 0;
    for (int c = 0; c < 100 && nd0 == 0; c++) tick;
    checks++; if (nd0 != 1 || q0.size() != 8 || q1.size() != 8) begin errors++; $display("FAIL ovf_drain got done=%0d n=%0d/%0d want 1 8/8", nd0, q0.size(), q1.size()); end
    for (int i = 0; i < 8 && i < q0.size() && i < q1.size(); i++) begin
      checks++; if (q0[i] !== dibit(bb[i/4], i%4, 0) || q1[i] !== dibit(bb[i/4], i%4, 1)) begin errors++; $display("FAIL ovf_data[%0d] got %b/%b want %b/%b", i, q0[i], q1[i], dibit(bb[i/4], i%4, 0), dibit(bb[i/4], i%4, 1)); end
    end
    checks++; if ({ov0, ov1} !== 2'b11) begin errors++; $display("FAIL ovf_sticky got %b want 11", {ov0, ov1}); end
  endtask

  task automatic test_random_8to2;
    logic [1:0] e0[$], e1[$];
    logic [7:0] b;
    int n, sent;
    apply_reset;
    n = $urandom_range(5, 12);
    sent = 0;
    for (int c = 0; c < 1000 && sent < n; c++) begin
      a_drdy = $urandom_range(0, 3) != 0;
      a_inclk = 0; a_in_done = 0;
      if (ry0 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        a_inclk = 1; a_in = b;
        for (int k = 0; k < 4; k++) begin e0.push_back(dibit(b, k, 0)); e1.push_back(dibit(b, k, 1)); end
        sent++;
        a_in_done = sent == n;
      end
      tick;
    end
    a_inclk = 0; a_in_done = 0; a_drdy = 1;
    for (int c = 0; c < 200 && (nd0 == 0 || nd1 == 0); c++) tick;
    checks++; if (sent != n || nd0 != 1 || nd1 != 1 || ov0 !== 1'b0) begin errors++; $display("FAIL rnd8_end got sent=%0d done=%0d/%0d ovf=%b want %0d 1/1 0", sent, nd0, nd1, ov0, n); end
    checks++; if (q0.size() != e0.size() || q1.size() != e1.size()) begin errors++; $display("FAIL rnd8_count got %0d/%0d want %0d", q0.size(), q1.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < q0.size() && i < q1.size(); i++) begin
      checks++; if (q0[i] !== e0[i] || q1[i] !== e1[i]) begin errors++; $display("FAIL rnd8_data[%0d] got %b/%b want %b/%b", i, q0[i], q1[i], e0[i], e1[i]); end
    end
  endtask

  task automatic test_random_2to8;
    logic [1:0] d[$];
    logic [7:0] e2[$], e3[$];
    logic [7:0] v;
    int n, sent;
    apply_reset;
    n = $urandom_range(5, 15);
    sent = 0;
    for (int c = 0; c < 1000 && sent < n; c++) begin
      b_drdy = $urandom_range(0, 3) != 0;
      b_inclk = 0; b_in_done = 0;
      if (ry2 && $urandom_range(0, 1) == 1) begin
        b_inclk = 1; b_in = 2'($urandom);
        d.push_back(b_in);
        sent++;
        b_in_done = sent == n;
      end
      tick;
    end
    b_inclk = 0; b_in_done = 0; b_drdy = 1;
    for (int j = 0; j < (n + 3) / 4; j++) begin
      v = 0;
      for (int k = 0; k < 4; k++) if (4*j + k < n) v = v | (8'(d[4*j + k]) << (2*k));
      e2.push_back(v);
      if (4*j + 3 < n) e3.push_back(v);
    end
    for (int c = 0; c < 200 && (nd2 == 0 || nd3 == 0); c++) tick;
    checks++; if (sent != n || nd2 != 1 || nd3 != 1) begin errors++; $display("FAIL rnd2_end got sent=%0d done=%0d/%0d want %0d 1/1", sent, nd2, nd3, n); end
    checks++; if (q2.size() != e2.size() || q3.size() != e3.size()) begin errors++; $display("FAIL rnd2_count got %0d/%0d want %0d/%0d", q2.size(), q3.size(), e2.size(), e3.size()); end
    for (int i = 0; i < e2.size() && i < q2.size(); i++) begin
      checks++; if (q2[i] !== e2[i]) begin errors++; $display("FAIL rnd2_pad[%0d] got %h want %h", i, q2[i], e2[i]); end
    end
    for (int i = 0; i < e3.size() && i < q3.size(); i++) begin
      checks++; if (q3[i] !== e3[i]) begin errors++; $display("FAIL rnd2_nopad[%0d] got %h want %h", i, q3[i], e3[i]); end
    end
  endtask

  task automatic test_credits;
    logic [1:0] e0[$];
    logic [7:0] b;
    int due[$];
    int n, reqs, sent;
    apply_reset;
    n = 10; reqs = 0; sent = 0;
    for (int c = 0; c < 2000 && sent < n; c++) begin
      a_inclk = 0; a_in_done = 0;
      a_drdy = $urandom_range(0, 3) != 0;
      if (rc0) begin reqs++; due.push_back(c + 2); end
      checks++; if (reqs - sent > 2) begin errors++; $display("FAIL credits_outstanding got %0d want <=2", reqs - sent); end
      if (due.size() > 0 && due[0] <= c) begin
        void'(due.pop_front());
        b = 8'($urandom);
        a_inclk = 1; a_in = b;
        for (int k = 0; k < 4; k++) e0.push_back(dibit(b, k, 0));
        sent++;
        a_in_done = sent == n;
      end
      tick;
    end
    a_inclk = 0; a_in_done = 0; a_drdy = 1;
    for (int c = 0; c < 200 && nd0 == 0; c++) tick;
    checks++; if (sent != n || nd0 != 1 || ov0 !== 1'b0) begin errors++; $display("FAIL credits_end got sent=%0d done=%0d ovf=%b want %0d 1 0", sent, nd0, ov0, n); end
    checks++; if (q0.size() != e0.size()) begin errors++; $display("FAIL credits_count got %0d want %0d", q0.size(), e0.size()); end
    for (int i = 0; i < e0.size() && i < q0.size(); i++) begin
      checks++; if (q0[i] !== e0[i]) begin errors++; $display("FAIL credits_data[%0d] got %b want %b", i, q0[i], e0[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    apply_reset;
    a_drdy = 1; a_inclk = 1; a_in = 8'hB4;
    tick;
    a_inclk = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    checks++; if ({oc0, rc0, dd0, ov0, ry0, o0} !== 7'b0000100) begin errors++; $display("FAIL midrst_u0 got %b want 0000100", {oc0, rc0, dd0, ov0, ry0, o0}); end
    checks++; if ({oc1, rc1, dd1, ov1, ry1, o1} !== 7'b0000100) begin errors++; $display("FAIL midrst_u1 got %b want 0000100", {oc1, rc1, dd1, ov1, ry1, o1}); end
    tick;
    rst = 0;
    repeat (6) tick;
    checks++; if (q0.size() != 2 || nd0 != 0 || nd1 != 0) begin errors++; $display("FAIL midrst_quiet got n=%0d done=%0d want n=2 done=0", q0.size(), nd0); end
    clear_q;
    b = 8'($urandom);
    a_inclk = 1; a_in = b; a_in_done = 1;
    tick;
    a_inclk = 0; a_in_done = 0;
    for (int c = 0; c < 50 && nd0 == 0; c++) tick;
    checks++; if (q0.size() != 4 || q1.size() != 4 || nd0 != 1) begin errors++; $display("FAIL midrst_fresh got n=%0d/%0d done=%0d want 4/4 1", q0.size(), q1.size(), nd0); end
    for (int i = 0; i < 4 && i < q0.size() && i < q1.size(); i++) begin
      checks++; if (q0[i] !== dibit(b, i, 0) || q1[i] !== dibit(b, i, 1)) begin errors++; $display("FAIL midrst_data[%0d] got %b/%b want %b/%b", i, q0[i], q1[i], dibit(b, i, 0), dibit(b, i, 1)); end
    end
  endtask

  initial begin
    test_reset;
    test_order;
    test_2to8;
    test_pad;
    test_overflow;
    repeat (3) test_random_8to2;
    repeat (3) test_random_2to8;
    test_credits;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
